// File: rtl/enc_pkg.sv
// Shared definitions for the priority encoder capture block.
// Holds the request count, the code width, the FSM state encoding and the
// lowest-set-bit helper. The helper gives bit 0 the highest priority, so the
// code it returns matches the board's 3-to-8 decoder (code 0 = bit 0).
package enc_pkg;

   localparam int NUM_REQ = 8;
   localparam int CODE_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Scanning from the top index down lets the lowest set bit overwrite any
   // higher one. The result is therefore the highest-priority request.
   // An all-zero input returns 0. Callers only use the result when the
   // mask is non-zero.
   function automatic logic [CODE_W-1:0] lowest_set(input logic [NUM_REQ-1:0] mask);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int n = NUM_REQ - 1; n >= 0; n--) begin
         if (mask[n]) begin
            idx = n[CODE_W-1:0];
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rising-edge detection, one lane per request.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset, clears every flop
//   req   - raw asynchronous request lines
//   rise  - one-cycle pulse per lane when the synchronized line goes 0 -> 1
// The chain resets to 0. A line held high across reset release therefore
// looks like a fresh rising edge and produces exactly one pulse.
module sync_edge #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] rise
);

   // A single flop offers no metastability protection, so the chain is
   // never allowed to be shorter than two stages.
   localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

   logic [WIDTH-1:0] chain [DEPTH];
   logic [WIDTH-1:0] prev;

   // The synchronizer chain and the one-cycle-delayed copy used for edge
   // detection. prev follows the last chain stage, so rise lasts exactly
   // one clock for each 0 -> 1 transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < DEPTH; n++) begin
            chain[n] <= '0;
         end
         prev <= '0;
      end else begin
         chain[0] <= req;
         for (int n = 1; n < DEPTH; n++) begin
            chain[n] <= chain[n-1];
         end
         prev <= chain[DEPTH-1];
      end
   end

   assign rise = chain[DEPTH-1] & ~prev;

endmodule

// File: rtl/prio_encoder_capture.sv
// Captures rising edges on eight asynchronous request lines into a pending
// mask. It presents the highest-priority pending request as a registered
// code, using a VALID/ACK handshake.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   EN     - capture enable; when low, new edges are not recorded
//   I      - raw request lines, bit n is request n
//   ACK    - consumer accepts the presented code
//   Y      - registered code of the presented request (holds when VALID=0)
//   VALID  - Y refers to a pending request
//   MULTI  - two or more requests are pending
//   PEND   - registered pending-request mask
module prio_encoder_capture
   import enc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               EN,
   input  logic [NUM_REQ-1:0] I,
   input  logic               ACK,
   output logic [CODE_W-1:0]  Y,
   output logic               VALID,
   output logic               MULTI,
   output logic [NUM_REQ-1:0] PEND
);

   state_t             state;
   logic [NUM_REQ-1:0] rise;
   logic [NUM_REQ-1:0] clr;

   sync_edge #(
      .WIDTH  (NUM_REQ),
      .STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .req  (I),
      .rise (rise)
   );

   // Only an accepted handshake clears a pending bit, and it clears only
   // the bit that was presented.
   always_comb begin
      clr = '0;
      if (state == HOLD && ACK) begin
         clr[Y] = 1'b1;
      end
   end

   // The set term is applied after the clear term. A new edge that lands
   // in the same cycle as its acknowledge therefore keeps the bit pending,
   // so the request is not lost. Repeated edges on a bit that is already
   // pending are absorbed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PEND <= '0;
      end else begin
         PEND <= (PEND & ~clr) | (rise & {NUM_REQ{EN}});
      end
   end

   // Handshake FSM. In HOLD, Y and VALID are frozen, so the consumer sees a
   // stable code even when higher-priority requests arrive. Every ACK forces
   // a pass through IDLE, and the next code is chosen there from the updated
   // mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         Y     <= '0;
         VALID <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|PEND) begin
                  Y     <= lowest_set(PEND);
                  VALID <= 1'b1;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (ACK) begin
                  VALID <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // x & (x - 1) removes the lowest set bit. Anything left over means at
   // least two bits were set. MULTI is driven only from the PEND register,
   // so it changes cleanly just after the clock edge.
   assign MULTI = |(PEND & (PEND - {{(NUM_REQ-1){1'b0}}, 1'b1}));

endmodule

// File: doc/prio_encoder_capture.md
Name: prio_encoder_capture

Overview:
- Inverse of the board's 3-to-8 one-hot decoder. Captures rising edges on 8 asynchronous request lines (buttons/switches) into a pending mask.
- Presents the highest-priority pending request as a registered 3-bit code, with a VALID/ACK handshake.
- Sits between board inputs and control logic, which consumes one code per ACK.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per request line (minimum 2).

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- EN  in  1  capture enable; when 0, new rising edges are not recorded.
- I  in  8  raw asynchronous request lines; bit n is request n.
- ACK  in  1  consumer accepts the presented code.
- Y  out  3  registered code of the presented request.
- VALID  out  1  Y holds a pending request.
- MULTI  out  1  more than one bit of PEND is set.
- PEND  out  8  pending-request mask, registered.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: all synchronizer, edge and PEND flops = 0, Y=0, VALID=0, MULTI=0, FSM=IDLE. Any in-flight request is discarded.
- Synchronizer: I passes through SYNC_STAGES flops (s). prev holds s delayed one clock. rise = s & ~prev.
- Because the synchronizer resets to 0, a line held high across reset release produces exactly one event.
- PEND update each clock: PEND <= (PEND & ~clr) | (rise & {8{EN}}).
  - clr is one-hot on Y only when FSM=HOLD and ACK=1; otherwise 0.
  - A new rise on the bit being cleared in the same cycle wins: that bit stays set.
- Repeated rises on an already-pending bit are absorbed; there is no counting.
- Priority: lowest index wins (bit 0 highest), matching decoder code 0 = bit 0.
- FSM states are IDLE and HOLD.
  - IDLE: VALID=0. If PEND != 0, load Y = index of lowest set bit of PEND, set VALID=1, go to HOLD. ACK in IDLE is ignored.
  - HOLD: Y and VALID are stable regardless of PEND changes. If ACK=1, clear PEND[Y], set VALID=0, go to IDLE. Y keeps its last value while VALID=0.
- Throughput: one code per 2 cycles at most, because a mandatory IDLE cycle follows every ACK.
- Latency: with I[n] sampled high at rising edge 1, PEND[n] rises at edge SYNC_STAGES+1. VALID rises at edge SYNC_STAGES+2 (edge 4 by default), given IDLE and no higher-priority pending bit.
- MULTI = (PEND has at least 2 bits set). It is combinational from the PEND register and glitch-free relative to clk.
- EN=0 only masks capture. Already-pending requests are still presented and acknowledged.
- Width rules: Y is 3 bits and covers 0..7. No overflow is possible. PEND never has bits set outside the 8 lines.

Decomposition:
- Shared package enc_pkg holds:
  - NUM_REQ=8 and CODE_W=3.
  - State encoding IDLE=1'b0, HOLD=1'b1.
  - A lowest-set-bit function returning CODE_W bits.
- One sub-module, sync_edge (width 8, SYNC_STAGES deep): synchronizer, prev register and rise output. It shares the same clk and rst.
- The top level holds PEND, the FSM, the priority function and the outputs.

Test Plan:
1. Assert rst with I=8'hFF mid-run -> immediately Y=0, VALID=0, PEND=0, MULTI=0. After release with I still 8'hFF: one event per line, first Y=0.
2. EN=1, pulse I[5] high for 3 cycles -> PEND=8'h20 at edge 3, VALID=1 and Y=5 at edge 4. Then ACK=1 for one cycle -> next edge VALID=0, PEND=8'h00.
3. I=8'h90 rising together -> Y=4, VALID=1, MULTI=1. ACK -> IDLE for 1 cycle, then Y=7, VALID=1, MULTI=0. ACK -> PEND=0.
4. EN=0, pulse I[2] -> PEND stays 8'h00, VALID stays 0. Then EN=1 with I[2] still high -> no event (no new edge).
5. While HOLD with Y=3, a new rise of I[3] coincides with ACK -> PEND[3] stays 1, VALID drops for one cycle, then re-asserts with Y=3.
6. While HOLD with Y=6, a rise on I[1] -> Y stays 6 until ACK, then Y=1 after the IDLE cycle. ACK held high in IDLE has no effect.
